// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared width default, FSM state encoding and FIFO pointer sizing for the GCD sequencer
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef logic [0:0] seq_state_t;
  localparam seq_state_t S_IDLE = 1'b0;
  localparam seq_state_t S_WAIT = 1'b1;

  // One extra pointer bit separates full from empty when the index bits match.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gcd_op_fifo.sv
// rtl/gcd_op_fifo.sv - synchronous operand FIFO with wrap-bit pointers
module gcd_op_fifo
  import gcd_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// rtl/gcd_job_sequencer.sv - buffers operand pairs, issues GCD jobs one at a time, holds one result
// Optional job tags travel with each job when GCD_SEQ_TAG_EN is defined.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef GCD_SEQ_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] res_tag,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             core_reset,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_outp,
  input  logic             core_done
);

`ifdef GCD_SEQ_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int DW = 2 * WIDTH + (TAG_EN ? TAG_W : 0);

  logic [DW-1:0]    fifo_din;
  logic [DW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_zero;
  seq_state_t       state;

  assign core_reset = !reset_n;
  assign in_ready   = reset_n && !fifo_full;
  // A full result slot blocks issue, including the cycle it drains.
  assign pop        = (state == S_IDLE) && !fifo_empty && !res_valid;
  assign head_a     = head[2*WIDTH-1:WIDTH];
  assign head_b     = head[WIDTH-1:0];
  assign head_zero  = (head_a == '0) || (head_b == '0);

`ifdef GCD_SEQ_TAG_EN
  assign fifo_din = {in_tag, in_a, in_b};
`else
  assign fifo_din = {in_a, in_b};
`endif

  gcd_op_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (in_valid && in_ready),
    .push_data(fifo_din),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      res_valid  <= 1'b0;
      res_data   <= '0;
      core_start <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
    end else begin
      core_start <= 1'b0;
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            // Zero operands yield 0 without involving the core.
            if (head_zero) begin
              res_data  <= '0;
              res_valid <= 1'b1;
            end else begin
              core_a     <= head_a;
              core_b     <= head_b;
              core_start <= 1'b1;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (core_done) begin
            res_data  <= core_outp;
            res_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GCD_SEQ_TAG_EN
  logic [TAG_W-1:0] job_tag;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      job_tag <= '0;
      res_tag <= '0;
    end else if (state == S_IDLE && pop) begin
      if (head_zero) res_tag <= head[DW-1:2*WIDTH];
      else           job_tag <= head[DW-1:2*WIDTH];
    end else if (state == S_WAIT && core_done) begin
      res_tag <= job_tag;
    end
  end
`endif

endmodule
